add_accumulator: RTL and testbench
==================================

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter: N_OPS, default 4, operands per result frame (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand byte present on in_data.
REQ-005 in_ready  output  1  block can accept an operand this cycle.
REQ-006 in_data  input  8  unsigned operand byte.
REQ-007 in_last  input  1  qualifies in_data as final operand of frame (early terminate).
REQ-008 out_valid  output  1  frame result present.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_sum  output  8  accumulated sum.
REQ-011 out_carry  output  1  sticky: any 8-bit addition in frame produced carry-out.
REQ-012 out_count  output  4  operands accepted in frame.

Function
REQ-013 Operand transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer where out_valid=1 and out_ready=1.
REQ-014 FSM SHALL have states IDLE, ACCUM, DONE; in_ready=1 in IDLE and ACCUM, 0 in DONE; out_valid=1 only in DONE.
REQ-015 IDLE transfer: acc<=in_data, carry<=0, cnt<=1; next DONE if in_last=1 or N_OPS=1, else ACCUM.
REQ-016 ACCUM transfer: {c,s}=acc+in_data (8-bit unsigned, 9-bit result via ripple-carry addition); acc<=s; carry<=carry|c; cnt<=cnt+1; next DONE if in_last=1 or cnt+1=N_OPS, else stay.
REQ-017 No transfer in IDLE/ACCUM: all state holds; in_last ignored when in_valid=0.
REQ-018 Latency: out_valid SHALL rise in the cycle after the edge accepting the final operand.
REQ-019 In DONE, out_sum=acc, out_carry=carry, out_count=cnt, held stable until output transfer.
REQ-020 DONE with out_ready=1: next state IDLE, out_valid low next cycle; no operand accepted in that cycle (one-cycle bubble between frames).
REQ-021 DONE with out_ready=0: remain in DONE indefinitely; in_valid ignored.
REQ-022 Sum wraps modulo 256 (unless REQ-027); e.g. 0xF0+0x20 gives 0x10, carry=1.
REQ-023 out_sum/out_carry/out_count SHALL read 0 whenever out_valid=0.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, acc=0, carry=0, cnt=0; in_ready=1, out_valid=0 from the next cycle.
REQ-025 rst SHALL take priority over any simultaneous transfer; a partial frame or unacknowledged result is discarded.
REQ-026 After rst deasserts, the first operand SHALL be accepted on the next edge with in_valid=1.

Configuration
REQ-027 Macro ACC_SATURATE_EN: when defined, an ACCUM addition with c=1 SHALL load acc<=0xFF (carry still set) and acc stays 0xFF for the rest of the frame; when undefined, wrap per REQ-022.
REQ-028 Handshake, latency and out_count behaviour SHALL be identical with or without ACC_SATURATE_EN.

Verification
REQ-029 N_OPS=4, operands 0x01,0x02,0x03,0x04 back-to-back, out_ready=1 -> out_valid one cycle after 4th, out_sum=0x0A, out_carry=0, out_count=4, then IDLE.
REQ-030 Operands 0x80,0x90,0x10,0x01 -> no macro: out_sum=0x21, out_carry=1; ACC_SATURATE_EN: out_sum=0xFF, out_carry=1.
REQ-031 Operands 0x05,0x06 with in_last on 2nd -> out_sum=0x0B, out_count=2, out_valid next cycle.
REQ-032 Result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no operand consumed; out_ready=1 -> IDLE, next operand accepted one cycle later.
REQ-033 rst=1 after 2 of 4 operands, then 0x07,0x01,0x01,0x01 -> out_sum=0x0A, out_count=4 (partial frame discarded).
REQ-034 N_OPS=1, operand 0xFF -> out_sum=0xFF, out_carry=0, out_count=1 one cycle later.

Source files
------------

// File: rtl/add_accumulator.sv
// Frame accumulator: sums N_OPS unsigned bytes (or fewer when in_last is seen)
// and reports sum, sticky carry and operand count. ACC_SATURATE_EN clamps the sum at 0xFF.
module add_accumulator #(
  parameter int N_OPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_carry,
  output logic [3:0] out_count
);

  localparam int DATA_W = 8;
  localparam logic [3:0] N_OPS_C = 4'(N_OPS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  logic              carry_q;
  logic [3:0]        cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [DATA_W:0]   add_r;
  logic [DATA_W-1:0] acc_d;
  logic [3:0]        cnt_d;
  logic              in_xfer;

  function automatic logic [DATA_W:0] ripple_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic              c;
    logic [DATA_W-1:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < DATA_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

`ifdef ACC_SATURATE_EN
  // Any carry-out pins the accumulator at full scale for the rest of the frame.
  function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W:0] r);
    return r[DATA_W] ? {DATA_W{1'b1}} : r[DATA_W-1:0];
  endfunction
`endif

  always_comb begin
    add_r = ripple_add(acc_q, in_data);
`ifdef ACC_SATURATE_EN
    acc_d = sat_sum(add_r);
`else
    acc_d = add_r[DATA_W-1:0];
`endif
    cnt_d   = cnt_q + 4'd1;
    in_xfer = in_valid && in_ready_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            acc_q   <= in_data;
            carry_q <= 1'b0;
            cnt_q   <= 4'd1;
            if (in_last || N_OPS == 1) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc_q   <= acc_d;
            carry_q <= carry_q | add_r[DATA_W];
            cnt_q   <= cnt_d;
            if (in_last || cnt_d == N_OPS_C) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // Returning through IDLE leaves one bubble cycle before the next frame.
          if (out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_valid_q ? acc_q   : '0;
  assign out_carry = out_valid_q ? carry_q : 1'b0;
  assign out_count = out_valid_q ? cnt_q   : '0;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed scoreboard bench for add_accumulator (N_OPS=4 and N_OPS=1 instances).
module tb_add_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_carry;
  logic [7:0] in_data, out_sum;
  logic [3:0] out_count;
  logic       in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_carry_b;
  logic [7:0] in_data_b, out_sum_b;
  logic [3:0] out_count_b;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic [3:0] count;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ops[$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  add_accumulator #(.N_OPS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .out_count(out_count)
  );

  add_accumulator #(.N_OPS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_last(in_last_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_sum(out_sum_b), .out_carry(out_carry_b),
    .out_count(out_count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, wrap or clamp after each addition.
  task automatic push_model(input logic [7:0] o[$]);
    exp_t e;
    int   s;
    s       = int'(o[0]);
    e.carry = 1'b0;
    for (int i = 1; i < o.size(); i++) begin
      s = s + int'(o[i]);
      if (s > 255) begin
        e.carry = 1'b1;
`ifdef ACC_SATURATE_EN
        s = 255;
`else
        s = s - 256;
`endif
      end
    end
    e.sum   = 8'(s);
    e.count = 4'(o.size());
    sb_q.push_back(e);
  endtask

  task automatic send_op(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    check("in_ready_before_op", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] o[$], input logic last_on_final);
    push_model(o);
    for (int i = 0; i < o.size(); i++)
      send_op(o[i], last_on_final && (i == o.size() - 1));
  endtask

  task automatic expect_result(input string tag);
    exp_t e;
    int   n;
    n = 0;
    check({tag, "_latency"}, 32'(out_valid), 32'd1);
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_sum"},   32'(out_sum),   32'(e.sum));
      check({tag, "_carry"}, 32'(out_carry), 32'(e.carry));
      check({tag, "_count"}, 32'(out_count), 32'(e.count));
    end
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_sum_zero"},   32'(out_sum),   32'd0);
      check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; in_last_b = 1'b0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;

    // Basic full frame; first operand taken on the very first edge after reset.
    ops = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(ops, 1'b0);
    expect_result("basic");

    ops = '{8'h80, 8'h90, 8'h10, 8'h01};
    send_frame(ops, 1'b0);
    expect_result("carry");

    ops = '{8'h05, 8'h06};
    send_frame(ops, 1'b1);
    expect_result("early_last");

    ops = '{8'hF0, 8'h20, 8'h00, 8'h00};
    send_frame(ops, 1'b0);
    expect_result("wrap");

    // in_last without in_valid must not end the frame.
    ops = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_model(ops);
    send_op(8'h01, 1'b0);
    in_last = 1'b1;
    @(posedge clk); #1;
    in_last = 1'b0;
    check("gap_last_ignored", 32'(out_valid), 32'd0);
    send_op(8'h02, 1'b0);
    send_op(8'h03, 1'b0);
    send_op(8'h04, 1'b0);
    expect_result("gap");

    // Backpressure: result held, operands refused while out_ready is low.
    out_ready = 1'b0;
    ops = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(ops, 1'b0);
    expect_result("stall");
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_sum",   32'(out_sum),   32'h0A0);
      check("stall_out_count", 32'(out_count), 32'd4);
    end
    ops = '{8'h55, 8'h01, 8'h01, 8'h01};
    push_model(ops);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready),  32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_first_op", 32'(out_valid), 32'd0);
    send_op(8'h01, 1'b0);
    send_op(8'h01, 1'b0);
    send_op(8'h01, 1'b0);
    expect_result("after_stall");

    // Reset mid-frame, with a competing transfer on the reset edge.
    send_op(8'h11, 1'b0);
    send_op(8'h22, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready),  32'd1);
    ops = '{8'h07, 8'h01, 8'h01, 8'h01};
    send_frame(ops, 1'b0);
    expect_result("after_rst");

    // Single-operand frames.
    ops = '{8'hFF, 8'h01};
    foreach (ops[k]) begin
      in_valid_b = 1'b1; in_data_b = ops[k];
      check("n1_in_ready", 32'(in_ready_b), 32'd1);
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      check("n1_valid", 32'(out_valid_b), 32'd1);
      check("n1_sum",   32'(out_sum_b),   32'(ops[k]));
      check("n1_carry", 32'(out_carry_b), 32'd0);
      check("n1_count", 32'(out_count_b), 32'd1);
      @(posedge clk); #1;
      check("n1_valid_drop", 32'(out_valid_b), 32'd0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
